// File: rtl/dti_rr_arbiter.sv
// N-way round-robin merge of DTI producer channels onto one registered consumer channel.
// With LOCK_EOT=1 a multi-item transaction keeps the grant until its eot item is forwarded.
module dti_rr_arbiter #(
   parameter int N        = 4,
   parameter int W_DATA   = 64,
   parameter int LOCK_EOT = 0,
   parameter int W_IDX    = $clog2(N)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N*W_DATA-1:0] din_data,
   input  logic [N-1:0]        din_valid,
   output logic [N-1:0]        din_ready,
   output logic [W_DATA-1:0]   dout_data,
   output logic                dout_valid,
   input  logic                dout_ready,
   output logic [W_IDX-1:0]    dout_idx
);

   typedef enum logic {
      IDLE,
      LOCKED
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [W_IDX-1:0]  ptr;
   logic [W_IDX-1:0]  ptr_nxt;
   logic [W_IDX-1:0]  lock_idx;
   logic [W_IDX-1:0]  lock_idx_nxt;
   logic [W_IDX-1:0]  hi_idx;
   logic [W_IDX-1:0]  lo_idx;
   logic              hi_found;
   logic              lo_found;
   logic [W_IDX-1:0]  rr_idx;
   logic              rr_found;
   logic [W_IDX-1:0]  grant_idx;
   logic              grant_valid;
   logic [W_DATA-1:0] grant_data;
   logic              grant_eot;
   logic              load_en;
   logic              xfer;

   if (N < 2) begin : g_check_n
      $error("dti_rr_arbiter: N must be at least 2");
   end

   if (LOCK_EOT != 0 && W_DATA < 1) begin : g_check_w
      $error("dti_rr_arbiter: LOCK_EOT needs W_DATA >= 1 to carry the eot bit");
   end

   function automatic logic [W_IDX-1:0] next_idx(input logic [W_IDX-1:0] idx);
      if (idx == W_IDX'(N - 1)) begin
         return '0;
      end
      return idx + W_IDX'(1);
   endfunction

   // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index overall.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (din_valid[i]) begin
            lo_found = 1'b1;
            lo_idx   = W_IDX'(i);
            if (i >= int'(ptr)) begin
               hi_found = 1'b1;
               hi_idx   = W_IDX'(i);
            end
         end
      end
      rr_found = lo_found;
      rr_idx   = hi_found ? hi_idx : lo_idx;
   end

   always_comb begin
      if (state == LOCKED) begin
         grant_idx   = lock_idx;
         grant_valid = din_valid[lock_idx];
      end else begin
         grant_idx   = rr_idx;
         grant_valid = rr_found;
      end
      grant_data = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_idx == W_IDX'(i)) begin
            grant_data = din_data[i*W_DATA +: W_DATA];
         end
      end
      grant_eot = grant_data[W_DATA-1];
   end

   assign load_en = !dout_valid || dout_ready;
   assign xfer    = grant_valid && load_en;

   // Ready is gated by reset so producers never see a handshake while the block is held in reset.
   always_comb begin
      din_ready = '0;
      if (xfer && rst) begin
         din_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      state_nxt    = state;
      lock_idx_nxt = lock_idx;
      ptr_nxt      = ptr;
      if (xfer) begin
         ptr_nxt = next_idx(grant_idx);
         case (state)
            IDLE: begin
               if (LOCK_EOT != 0 && !grant_eot) begin
                  state_nxt    = LOCKED;
                  lock_idx_nxt = grant_idx;
               end
            end
            LOCKED: begin
               if (grant_eot) begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         ptr      <= '0;
         lock_idx <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         lock_idx <= lock_idx_nxt;
      end
   end

   // Data and index only move on a transfer; a drain clears valid but keeps the last item visible.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout_valid <= 1'b0;
         dout_data  <= '0;
         dout_idx   <= '0;
      end else if (load_en) begin
         if (xfer) begin
            dout_valid <= 1'b1;
            dout_data  <= grant_data;
            dout_idx   <= grant_idx;
         end else begin
            dout_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dti_rr_arbiter.sv
// Bench for dti_rr_arbiter: one plain round-robin instance and one eot-locking instance,
// selected by sel, exercised with a vector table, directed corner cases and random traffic.
module tb_dti_rr_arbiter;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int WI = 2;

   typedef struct {
      logic [N-1:0]  vld;
      logic          drdy;
      logic [N-1:0]  exp_rdy;
      logic          exp_ov;
      logic [WI-1:0] exp_idx;
   } vec_t;

   logic           clk     = 1'b0;
   logic           rst     = 1'b0;
   logic           sel     = 1'b0;
   logic [N*W-1:0] d_data  = '0;
   logic [N-1:0]   d_valid = '0;
   logic           d_ready = 1'b1;

   logic [N-1:0]  valid_a, valid_b, ready_a, ready_b, act_ready;
   logic          drdy_a, drdy_b, ov_a, ov_b, act_ov;
   logic [W-1:0]  data_a, data_b, act_data;
   logic [WI-1:0] idx_a, idx_b, act_idx;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign valid_a   = sel ? '0 : d_valid;
   assign valid_b   = sel ? d_valid : '0;
   assign drdy_a    = sel ? 1'b1 : d_ready;
   assign drdy_b    = sel ? d_ready : 1'b1;
   assign act_ready = sel ? ready_b : ready_a;
   assign act_ov    = sel ? ov_b : ov_a;
   assign act_data  = sel ? data_b : data_a;
   assign act_idx   = sel ? idx_b : idx_a;

   dti_rr_arbiter #(.N(N), .W_DATA(W), .LOCK_EOT(0)) u_rr (
      .clk(clk), .rst(rst), .din_data(d_data), .din_valid(valid_a), .din_ready(ready_a),
      .dout_data(data_a), .dout_valid(ov_a), .dout_ready(drdy_a), .dout_idx(idx_a)
   );

   dti_rr_arbiter #(.N(N), .W_DATA(W), .LOCK_EOT(1)) u_lk (
      .clk(clk), .rst(rst), .din_data(d_data), .din_valid(valid_b), .din_ready(ready_b),
      .dout_data(data_b), .dout_valid(ov_b), .dout_ready(drdy_b), .dout_idx(idx_b)
   );

   function automatic logic [W-1:0] chan_data(input int i);
      return W'(16'h00A0 + i);
   endfunction

   function automatic vec_t mk(input logic [N-1:0] vld, input logic drdy,
                               input logic [N-1:0] exp_rdy, input logic exp_ov,
                               input logic [WI-1:0] exp_idx);
      vec_t v;
      v.vld = vld; v.drdy = drdy; v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_idx = exp_idx;
      return v;
   endfunction

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [N-1:0] vld, input logic drdy);
      d_valid = vld;
      d_ready = drdy;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_chan(input int i, input logic [W-1:0] val);
      d_data[i*W +: W] = val;
   endtask

   task automatic check_out(input string name, input logic ov, input logic [W-1:0] data,
                            input logic [WI-1:0] idx);
      check_output({name, "_valid"}, 64'(act_ov), 64'(ov));
      check_output({name, "_data"}, 64'(act_data), 64'(data));
      check_output({name, "_idx"}, 64'(act_idx), 64'(idx));
   endtask

   task automatic do_reset(input logic which);
      rst     = 1'b0;
      sel     = which;
      d_valid = '0;
      d_ready = 1'b1;
      d_data  = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   task automatic run_random(input logic which, input int cycles);
      logic [N-1:0]  p_valid;
      logic [W-1:0]  p_data [N];
      logic [WI-1:0] m_ptr, m_lock, m_oi;
      logic          m_locked, m_ov, m_load, gv;
      logic [W-1:0]  m_od;
      logic [N-1:0]  exp_rdy;
      int            g, best;
      do_reset(which);
      p_valid = '0;
      m_ptr = '0; m_lock = '0; m_oi = '0; m_locked = 1'b0; m_ov = 1'b0; m_od = '0;
      for (int i = 0; i < N; i++) p_data[i] = '0;
      for (int c = 0; c < cycles; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!p_valid[i] && $urandom_range(0, 2) != 0) begin
               p_valid[i] = 1'b1;
               p_data[i]  = W'($urandom);
               if (which) p_data[i][W-1] = ($urandom_range(0, 2) == 0);
               set_chan(i, p_data[i]);
            end
         end
         apply_stimulus(p_valid, $urandom_range(0, 3) != 0);
         m_load = !m_ov || d_ready;
         gv = 1'b0; g = 0; best = N;
         if (m_locked) begin
            g  = int'(m_lock);
            gv = p_valid[g];
         end else begin
            for (int i = 0; i < N; i++) begin
               if (p_valid[i] && ((i - int'(m_ptr) + N) % N) < best) begin
                  best = (i - int'(m_ptr) + N) % N;
                  g    = i;
                  gv   = 1'b1;
               end
            end
         end
         exp_rdy = (gv && m_load) ? (N'(1) << g) : '0;
         check_output($sformatf("rnd%0d_c%0d_ready", which, c), 64'(act_ready), 64'(exp_rdy));
         tick();
         if (gv && m_load) begin
            m_ov     = 1'b1;
            m_od     = p_data[g];
            m_oi     = WI'(g);
            m_ptr    = WI'((g + 1) % N);
            m_locked = which && !p_data[g][W-1];
            m_lock   = WI'(g);
            p_valid[g] = 1'b0;
         end else if (m_load) begin
            m_ov = 1'b0;
         end
         check_out($sformatf("rnd%0d_c%0d", which, c), m_ov, m_od, m_oi);
      end
   endtask

   vec_t vecs [13];

   initial begin
      vecs[0]  = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);
      vecs[1]  = mk(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1);
      vecs[2]  = mk(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2);
      vecs[3]  = mk(4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3);
      vecs[4]  = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);
      vecs[5]  = mk(4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1);
      vecs[6]  = mk(4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3);
      vecs[7]  = mk(4'b1010, 1'b0, 4'b0000, 1'b1, 2'd3);
      vecs[8]  = mk(4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1);
      vecs[9]  = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1);
      vecs[10] = mk(4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2);
      vecs[11] = mk(4'b0001, 1'b0, 4'b0000, 1'b1, 2'd2);
      vecs[12] = mk(4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0);

      // Reset mid-stream: a held 0xAB item is dropped and the pointer restarts at input 0.
      do_reset(1'b0);
      set_chan(1, 16'h00AB);
      apply_stimulus(4'b0010, 1'b0);
      check_output("rst_load_ready", 64'(act_ready), 64'(4'b0010));
      tick();
      check_out("rst_loaded", 1'b1, 16'h00AB, 2'd1);
      rst = 1'b0;
      #1;
      apply_stimulus(4'b1111, 1'b1);
      check_out("rst_asserted", 1'b0, 16'h0000, 2'd0);
      check_output("rst_asserted_ready", 64'(act_ready), 64'(0));
      for (int i = 0; i < N; i++) set_chan(i, chan_data(i));
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_output("rst_first_ready", 64'(act_ready), 64'(4'b0001));
      tick();
      check_out("rst_first_grant", 1'b1, chan_data(0), 2'd0);

      // Vector table: fairness, skip, wrap-around and backpressure on the plain instance.
      do_reset(1'b0);
      for (int i = 0; i < N; i++) set_chan(i, chan_data(i));
      for (int k = 0; k < 13; k++) begin
         apply_stimulus(vecs[k].vld, vecs[k].drdy);
         check_output($sformatf("vec%0d_ready", k), 64'(act_ready), 64'(vecs[k].exp_rdy));
         tick();
         check_out($sformatf("vec%0d", k), vecs[k].exp_ov, chan_data(int'(vecs[k].exp_idx)),
                   vecs[k].exp_idx);
      end

      // Backpressure: 0x55 held for 5 cycles, then drain and refill in the same cycle.
      do_reset(1'b0);
      set_chan(2, 16'h0055);
      apply_stimulus(4'b0100, 1'b0);
      check_output("bp_load_ready", 64'(act_ready), 64'(4'b0100));
      tick();
      check_out("bp_load", 1'b1, 16'h0055, 2'd2);
      set_chan(2, 16'h0056);
      for (int c = 0; c < 5; c++) begin
         apply_stimulus(4'b0100, 1'b0);
         check_output($sformatf("bp_hold%0d_ready", c), 64'(act_ready), 64'(0));
         tick();
         check_out($sformatf("bp_hold%0d", c), 1'b1, 16'h0055, 2'd2);
      end
      apply_stimulus(4'b0100, 1'b1);
      check_output("bp_refill_ready", 64'(act_ready), 64'(4'b0100));
      tick();
      check_out("bp_refill", 1'b1, 16'h0056, 2'd2);
      apply_stimulus(4'b0000, 1'b1);
      tick();
      check_out("bp_drain", 1'b0, 16'h0056, 2'd2);

      // Eot lock: input 0 sends A, B, C(eot) while input 1 waits.
      do_reset(1'b1);
      set_chan(1, 16'h0011);
      set_chan(0, 16'h00A1);
      apply_stimulus(4'b0011, 1'b1);
      check_output("lock_a_ready", 64'(act_ready), 64'(4'b0001));
      tick();
      check_out("lock_a", 1'b1, 16'h00A1, 2'd0);
      set_chan(0, 16'h00B2);
      apply_stimulus(4'b0011, 1'b1);
      check_output("lock_b_ready", 64'(act_ready), 64'(4'b0001));
      tick();
      check_out("lock_b", 1'b1, 16'h00B2, 2'd0);
      set_chan(0, 16'h80C3);
      apply_stimulus(4'b0011, 1'b1);
      check_output("lock_c_ready", 64'(act_ready), 64'(4'b0001));
      tick();
      check_out("lock_c", 1'b1, 16'h80C3, 2'd0);
      apply_stimulus(4'b0010, 1'b1);
      check_output("lock_next_ready", 64'(act_ready), 64'(4'b0010));
      tick();
      check_out("lock_next", 1'b1, 16'h0011, 2'd1);

      // Lock stall: input 2 locks, goes quiet, input 0 must wait until 2's eot item.
      do_reset(1'b1);
      set_chan(2, 16'h0022);
      set_chan(0, 16'h0001);
      apply_stimulus(4'b0100, 1'b1);
      check_output("stall_lock_ready", 64'(act_ready), 64'(4'b0100));
      tick();
      check_out("stall_lock", 1'b1, 16'h0022, 2'd2);
      for (int c = 0; c < 3; c++) begin
         apply_stimulus(4'b0001, 1'b1);
         check_output($sformatf("stall%0d_ready", c), 64'(act_ready), 64'(0));
         tick();
         check_out($sformatf("stall%0d", c), 1'b0, 16'h0022, 2'd2);
      end
      set_chan(2, 16'h8023);
      apply_stimulus(4'b0101, 1'b1);
      check_output("stall_eot_ready", 64'(act_ready), 64'(4'b0100));
      tick();
      check_out("stall_eot", 1'b1, 16'h8023, 2'd2);
      apply_stimulus(4'b0001, 1'b1);
      check_output("stall_after_ready", 64'(act_ready), 64'(4'b0001));
      tick();
      check_out("stall_after", 1'b1, 16'h0001, 2'd0);

      run_random(1'b0, 400);
      run_random(1'b1, 400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
